// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for a 200x150 12-bit frame buffer: one clipped pixel per clk_px, row-major.
// Optional power-up clear of the whole buffer when FB_CLEAR_ON_RESET_EN is defined.
module fb_rect_writer #(
    parameter int H_RES = 200,
    parameter int V_RES = 150,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          clk_px,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic [7:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [DW-1:0] cmd_color,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLIP,
        S_FILL,
        S_DONE
`ifdef FB_CLEAR_ON_RESET_EN
        , S_CLEAR
`endif
    } state_e;

    localparam logic [8:0]    H_RES9 = 9'(H_RES);
    localparam logic [8:0]    V_RES9 = 9'(V_RES);
    localparam logic [AW-1:0] H_RES_A = AW'(H_RES);
`ifdef FB_CLEAR_ON_RESET_EN
    localparam logic [AW:0]   CLR_TOTAL = (AW+1)'(H_RES * V_RES);
    logic [AW:0]   clr_cnt_q;
`endif

    state_e        state_q;
    logic [7:0]    x0_q, y0_q, w_q, h_q;
    logic [DW-1:0] color_q;
    logic [7:0]    x_end_q, y_end_q;
    logic [7:0]    cx_q, cy_q;
    logic [AW-1:0] row_base_q;
    logic          we_q, busy_q, done_q, ready_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;

    logic [8:0]    x_sum, y_sum, x_lim, y_lim, x_end_d, y_end_d;
    logic          clip_empty, last_col, last_px;
    logic [AW-1:0] base0;
    logic [7:0]    cx_d, cy_d;
    logic [AW-1:0] row_base_d;

    // NOTE: every signal gets a value on every path here, so no latches are inferred.
    always_comb begin
        x_sum      = {1'b0, x0_q} + {1'b0, w_q};
        y_sum      = {1'b0, y0_q} + {1'b0, h_q};
        x_lim      = (x_sum > H_RES9) ? H_RES9 : x_sum;
        y_lim      = (y_sum > V_RES9) ? V_RES9 : y_sum;
        x_end_d    = x_lim - 9'd1;
        y_end_d    = y_lim - 9'd1;
        clip_empty = ({1'b0, x0_q} >= H_RES9) || ({1'b0, y0_q} >= V_RES9)
                     || (w_q == 8'd0) || (h_q == 8'd0);
        base0      = AW'(y0_q) * H_RES_A;
        last_col   = (cx_q == x_end_q);
        last_px    = last_col && (cy_q == y_end_q);
        cx_d       = last_col ? x0_q : cx_q + 8'd1;
        cy_d       = last_col ? cy_q + 8'd1 : cy_q;
        row_base_d = last_col ? row_base_q + H_RES_A : row_base_q;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // the command payload and pixel counters are not reset because they are reloaded before use.
    always_ff @(posedge clk_px) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef FB_CLEAR_ON_RESET_EN
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
`else
            state_q <= S_IDLE;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        x0_q    <= cmd_x;
                        y0_q    <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (clip_empty) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        x_end_q    <= x_end_d[7:0];
                        y_end_q    <= y_end_d[7:0];
                        cx_q       <= x0_q;
                        cy_q       <= y0_q;
                        row_base_q <= base0;
                        we_q       <= 1'b1;
                        waddr_q    <= base0 + AW'(x0_q);
                        wdata_q    <= color_q;
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Outputs already carry pixel (cx, cy); advance to the next one.
                    if (last_px) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cx_q       <= cx_d;
                        cy_q       <= cy_d;
                        row_base_q <= row_base_d;
                        we_q       <= 1'b1;
                        waddr_q    <= row_base_d + AW'(cx_d);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
`ifdef FB_CLEAR_ON_RESET_EN
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_TOTAL) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        busy_q    <= 1'b1;
                        we_q      <= 1'b1;
                        waddr_q   <= clr_cnt_q[AW-1:0];
                        wdata_q   <= '0;
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Randomized bench for fb_rect_writer: a rectangle-clipping model predicts every cycle after each handshake.
module tb_fb_rect_writer;
    localparam int H = 200;
    localparam int V = 150;
    localparam int AW = 15;
    localparam int DW = 12;

    logic          clk_px = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_x, cmd_y, cmd_w, cmd_h;
    logic [DW-1:0] cmd_color;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk_px = ~clk_px;

    fb_rect_writer #(.H_RES(H), .V_RES(V), .AW(AW), .DW(DW)) dut (
        .clk_px(clk_px), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: list of addresses covered by the screen-clipped rectangle, row-major.
    task automatic model_rect(input int x, input int y, input int w, input int h);
        int xe, ye;
        exp_q.delete();
        xe = (x + w < H) ? x + w : H;
        ye = (y + h < V) ? y + h : V;
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_q.push_back(r * H + c);
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h,
                             input logic [DW-1:0] color, input bit hold);
        int waited = 0;
        @(negedge clk_px);
        while (!cmd_ready && waited < 64) begin
            @(negedge clk_px);
            waited++;
        end
        check("ready_wait", 64'(cmd_ready), 64'(1));
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
        @(posedge clk_px);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Checks cycles N+1 .. N+3+K following the handshake edge.
    task automatic expect_cmd(input string tag, input logic [DW-1:0] color);
        int k_px = exp_q.size();
        logic e_we, e_done, e_busy, e_rdy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        for (int k = 1; k <= k_px + 3; k++) begin
            @(negedge clk_px);
            e_we   = (k >= 2) && (k <= k_px + 1);
            e_done = (k == k_px + 2);
            e_busy = (k <= k_px + 2);
            e_rdy  = (k == k_px + 3);
            e_addr = e_we ? AW'(exp_q[k-2]) : '0;
            e_data = e_we ? color : '0;
            check($sformatf("%s@%0d", tag, k),
                  64'({cmd_ready, done, busy, we, e_we ? waddr : AW'(0), e_we ? wdata : DW'(0)}),
                  64'({e_rdy, e_done, e_busy, e_we, e_addr, e_data}));
        end
    endtask

    task automatic run_cmd(input string tag, input int x, input int y, input int w,
                           input int h, input logic [DW-1:0] color);
        model_rect(x, y, w, h);
        drive_cmd(x, y, w, h, color, 1'b0);
        expect_cmd(tag, color);
    endtask

    task automatic run_random(input int n);
        int x, y, w, h;
        logic [DW-1:0] c;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(215, 0);
            y = $urandom_range(165, 0);
            w = $urandom_range(30, 0);
            h = $urandom_range(30, 0);
            c = DW'($urandom);
            run_cmd($sformatf("rand%0d", i), x, y, w, h, c);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(posedge clk_px);
        #1;
        check("reset_outs", 64'({we, waddr, wdata, done, busy, cmd_ready}), 64'(0));
        @(negedge clk_px);
        rstn = 1'b1;
        @(posedge clk_px);
        #1;
        check("ready_after_rst", 64'({cmd_ready, busy, we}), 64'(3'b100));

        run_cmd("full", 0, 0, 200, 150, 12'hF00);
        run_cmd("corner", 190, 145, 20, 20, 12'h0F0);
        run_cmd("empty_w", 10, 10, 0, 5, 12'h123);
        run_cmd("empty_h", 10, 10, 5, 0, 12'h456);
        run_cmd("empty_x", 200, 0, 4, 4, 12'h789);
        run_cmd("empty_y", 0, 150, 4, 4, 12'hABC);

        // Second command held valid throughout the first must wait for cmd_ready.
        model_rect(3, 2, 2, 2);
        drive_cmd(3, 2, 2, 2, 12'h00F, 1'b1);
        cmd_x = 8'd50; cmd_y = 8'd60; cmd_w = 8'd3; cmd_h = 8'd2; cmd_color = 12'h5A5;
        expect_cmd("collide_a", 12'h00F);
        @(posedge clk_px);
        #1;
        cmd_valid = 1'b0;
        model_rect(50, 60, 3, 2);
        expect_cmd("collide_b", 12'h5A5);

        run_random(30);

        // Reset in the middle of a full-screen fill.
        model_rect(0, 0, 200, 150);
        drive_cmd(0, 0, 200, 150, 12'h0FF, 1'b0);
        repeat (1000) @(negedge clk_px);
        rstn = 1'b0;
        @(posedge clk_px);
        #1;
        check("midrst_abort", 64'({we, busy, done}), 64'(0));
        repeat (2) @(negedge clk_px);
        rstn = 1'b1;
        @(posedge clk_px);
        #1;
        check("midrst_release", 64'({cmd_ready, busy, we, done}), 64'(4'b1000));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_px);
            check($sformatf("midrst_idle%0d", i), 64'({cmd_ready, busy, we, done}), 64'(4'b1000));
        end

        run_random(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
